// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - shared op codes, ALUOp constants, FSM state type and op classifiers
//
// Purpose: common definitions for the ALU operation decoder and sequencer.
// Ports:   none (package).
package alu_op_pkg;

  // ALU operation codes
  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_ADD    = 5'h03;
  localparam logic [4:0] OP_SUB    = 5'h04;
  localparam logic [4:0] OP_SRL    = 5'h05;
  localparam logic [4:0] OP_SRA    = 5'h06;
  localparam logic [4:0] OP_SLL    = 5'h07;
  localparam logic [4:0] OP_EQ     = 5'h08;
  localparam logic [4:0] OP_NE     = 5'h09;
  localparam logic [4:0] OP_LT     = 5'h0A;
  localparam logic [4:0] OP_GE     = 5'h0B;
  localparam logic [4:0] OP_SRCA   = 5'h0C;
  localparam logic [4:0] OP_SRCB   = 5'h0D;
  localparam logic [4:0] OP_LTU    = 5'h0E;
  localparam logic [4:0] OP_GEU    = 5'h0F;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  // ALUOp field values
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_UJ     = 2'b11;

  // Funct7 values that select the operation groups
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

  // MUL class occupies codes 10..13, DIV/REM class 14..17
  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/Funct3/Funct7 to ALU operation decoder
//
// Purpose: maps decode fields to an operation code, an illegal flag and the
//          number of cycles the operation occupies the ALU.
// Ports:   aluop_i, is_imm_i, funct7_i, funct3_i  - decode fields
//          op_o       - 5-bit operation code (ADD when illegal)
//          illegal_o  - encoding unsupported
//          cycles_o   - occupancy in cycles (1..15)
module alu_op_decode
  import alu_op_pkg::*;
#(
  parameter bit EN_M       = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic [1:0] aluop_i,
  input  logic       is_imm_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic [4:0] op_o,
  output logic       illegal_o,
  output logic [3:0] cycles_o
);

  logic [4:0] op;
  logic       ill;

  always_comb begin
    op  = OP_ADD;
    ill = 1'b0;
    case (aluop_i)
      ALUOP_MEM: op = OP_ADD;
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b000:  op = OP_EQ;
          3'b001:  op = OP_NE;
          3'b100:  op = OP_LT;
          3'b101:  op = OP_GE;
          3'b110:  op = OP_LTU;
          3'b111:  op = OP_GEU;
          default: ill = 1'b1;
        endcase
      end
      ALUOP_ARITH: begin
        // Immediate forms share the base table; Funct7 only matters for shifts,
        // and for register forms it is known to be zero on this path.
        if (is_imm_i || funct7_i == F7_BASE) begin
          case (funct3_i)
            3'b000: op = OP_ADD;
            3'b001: begin
              if (funct7_i == F7_BASE) op = OP_SLL;
              else                     ill = 1'b1;
            end
            3'b010: op = OP_LT;
            3'b011: op = OP_LTU;
            3'b100: op = OP_XOR;
            3'b101: begin
              if (funct7_i == F7_BASE)     op = OP_SRL;
              else if (funct7_i == F7_ALT) op = OP_SRA;
              else                         ill = 1'b1;
            end
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          case (funct3_i)
            3'b000:  op = OP_SUB;
            3'b101:  op = OP_SRA;
            default: ill = 1'b1;
          endcase
        end else if (funct7_i == F7_MULDIV && EN_M) begin
          op = {2'b10, funct3_i};
        end else begin
          ill = 1'b1;
        end
      end
      default: op = OP_SRCB;
    endcase
    if (ill) op = OP_ADD;
  end

  assign op_o      = op;
  assign illegal_o = ill;
  assign cycles_o  = is_mul(op) ? 4'(MUL_CYCLES) :
                     is_div(op) ? 4'(DIV_CYCLES) : 4'd1;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered ALU operation sequencer with multi-cycle M-op occupancy
//
// Purpose: decodes ALU fields, registers the operation and holds it valid for
//          the occupancy window of multi-cycle multiply/divide operations.
// Ports:   clk, reset (sync, active-high), flush - control
//          in_valid / in_ready                  - input handshake
//          ALUOp, IsImm, Funct7, Funct3         - decode fields
//          Operation, op_valid, op_last, illegal - registered outputs
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter bit EN_M       = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic            IsImm,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  output logic [OP_W-1:0] Operation,
  output logic            op_valid,
  output logic            op_last,
  output logic            illegal
);

  logic [4:0]      dec_op;
  logic            dec_illegal;
  logic [3:0]      dec_cycles;

  state_e          state_q;
  logic [3:0]      count_q;
  logic [3:0]      count_d;
  logic [OP_W-1:0] operation_q;
  logic            op_valid_q;
  logic            op_last_q;
  logic            illegal_q;

  alu_op_decode #(
    .EN_M       (EN_M),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_decode (
    .aluop_i   (ALUOp),
    .is_imm_i  (IsImm),
    .funct7_i  (Funct7),
    .funct3_i  (Funct3),
    .op_o      (dec_op),
    .illegal_o (dec_illegal),
    .cycles_o  (dec_cycles)
  );

  // Saturating decrement
  assign count_d = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      operation_q <= '0;
      op_valid_q  <= 1'b0;
      op_last_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_valid_q <= 1'b0;
      op_last_q  <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          count_q <= count_d;
          if (count_d == 4'd0) begin
            state_q   <= ISSUE;
            op_last_q <= 1'b1;
          end
        end
        default: begin
          // IDLE and ISSUE both accept, which gives back-to-back issue.
          if (in_valid) begin
            operation_q <= OP_W'(dec_op);
            illegal_q   <= dec_illegal;
            op_valid_q  <= 1'b1;
            if (dec_cycles <= 4'd1) begin
              state_q   <= ISSUE;
              op_last_q <= 1'b1;
              count_q   <= '0;
            end else begin
              state_q   <= BUSY;
              op_last_q <= 1'b0;
              count_q   <= dec_cycles - 4'd1;
            end
          end else begin
            state_q    <= IDLE;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q != BUSY);
  assign Operation = operation_q;
  assign op_valid  = op_valid_q;
  assign op_last   = op_last_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] aluop = 2'b00;
  logic       is_imm = 1'b0;
  logic [6:0] f7 = 7'h00;
  logic [2:0] f3 = 3'h0;

  logic [4:0] d_op   [2];
  logic       d_vld  [2];
  logic       d_last [2];
  logic       d_ill  [2];
  logic       d_rdy  [2];

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  // Instance 0: M enabled, MUL=4, DIV=8. Instance 1: M disabled.
  int mcyc [2] = '{4, 2};
  int dcyc [2] = '{8, 8};
  bit men  [2] = '{1'b1, 1'b0};

  alu_op_sequencer #(.OP_W(5), .EN_M(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_rdy[0]),
    .ALUOp(aluop), .IsImm(is_imm), .Funct7(f7), .Funct3(f3),
    .Operation(d_op[0]), .op_valid(d_vld[0]), .op_last(d_last[0]), .illegal(d_ill[0])
  );

  alu_op_sequencer #(.OP_W(5), .EN_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(8)) u_dut_nom (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_rdy[1]),
    .ALUOp(aluop), .IsImm(is_imm), .Funct7(f7), .Funct3(f3),
    .Operation(d_op[1]), .op_valid(d_vld[1]), .op_last(d_last[1]), .illegal(d_ill[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the op tables: returns {illegal, op}
  function automatic logic [5:0] ref_dec(input logic [1:0] a, input logic imm,
                                         input logic [6:0] s7, input logic [2:0] s3,
                                         input bit en_m);
    int br[8];
    int base[8];
    int op;
    br   = '{8, 9, -1, -1, 10, 11, 14, 15};
    base = '{3, 7, 10, 14, 2, 5, 1, 0};
    op   = -1;
    if (a == 2'd0) op = 3;
    else if (a == 2'd3) op = 13;
    else if (a == 2'd1) op = br[s3];
    else if (imm) begin
      if (s3 == 3'd1)      op = (s7 == 7'h00) ? 7 : -1;
      else if (s3 == 3'd5) op = (s7 == 7'h00) ? 5 : (s7 == 7'h20) ? 6 : -1;
      else                 op = base[s3];
    end else if (s7 == 7'h00) op = base[s3];
    else if (s7 == 7'h20) op = (s3 == 3'd0) ? 4 : (s3 == 3'd5) ? 6 : -1;
    else if (s7 == 7'h01 && en_m) op = 16 + int'(s3);
    if (op < 0) return {1'b1, 5'd3};
    return {1'b0, 5'(op)};
  endfunction

  function automatic int ref_cycles(input int i, input logic [4:0] op);
    if (op >= 5'h10 && op <= 5'h13) return mcyc[i];
    if (op >= 5'h14 && op <= 5'h17) return dcyc[i];
    return 1;
  endfunction

  // Model: remaining cycles of the current occupancy window
  int         rem  [2] = '{0, 0};
  logic [4:0] mop  [2] = '{5'd0, 5'd0};
  logic       mill [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [5:0] d;
      if (reset) begin
        rem[i] = 0; mop[i] = 5'd0; mill[i] = 1'b0;
      end else if (flush) begin
        rem[i] = 0;
      end else if (in_valid && rem[i] <= 1) begin
        d       = ref_dec(aluop, is_imm, f7, f3, men[i]);
        mop[i]  = d[4:0];
        mill[i] = d[5];
        rem[i]  = ref_cycles(i, d[4:0]);
      end else if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_op_valid", i), 32'(d_vld[i]), 32'(rem[i] > 0));
        chk($sformatf("m%0d_op_last", i), 32'(d_last[i]), 32'(rem[i] == 1));
        chk($sformatf("m%0d_in_ready", i), 32'(d_rdy[i]), 32'(rem[i] <= 1));
        if (rem[i] > 0) begin
          chk($sformatf("m%0d_Operation", i), 32'(d_op[i]), 32'(mop[i]));
          chk($sformatf("m%0d_illegal", i), 32'(d_ill[i]), 32'(mill[i]));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] a, input logic im,
                        input logic [6:0] s7, input logic [2:0] s3);
    in_valid = v; aluop = a; is_imm = im; f7 = s7; f3 = s3;
  endtask

  task automatic single(input string nm, input logic [1:0] a, input logic im,
                        input logic [6:0] s7, input logic [2:0] s3,
                        input int di, input logic [4:0] eop, input logic eill);
    set_in(1'b1, a, im, s7, s3);
    tick;
    chk({nm, "_op"}, 32'(d_op[di]), 32'(eop));
    chk({nm, "_valid"}, 32'(d_vld[di]), 32'd1);
    chk({nm, "_last"}, 32'(d_last[di]), 32'd1);
    chk({nm, "_illegal"}, 32'(d_ill[di]), 32'(eill));
    in_valid = 1'b0;
    tick;
    chk({nm, "_valid_after"}, 32'(d_vld[di]), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_op"}, 32'(d_op[0]), 32'd0);
    chk({nm, "_valid"}, 32'(d_vld[0]), 32'd0);
    chk({nm, "_last"}, 32'(d_last[0]), 32'd0);
    chk({nm, "_illegal"}, 32'(d_ill[0]), 32'd0);
    chk({nm, "_ready"}, 32'(d_rdy[0]), 32'd1);
  endtask

  initial begin
    tick;
    tick;
    chk_reset_vals("reset");
    reset = 1'b0;
    model_on = 1'b1;

    single("sub",   2'b10, 1'b0, 7'h20, 3'd0, 0, 5'h04, 1'b0);
    single("addi",  2'b10, 1'b1, 7'h20, 3'd0, 0, 5'h03, 1'b0);
    single("srai",  2'b10, 1'b1, 7'h20, 3'd5, 0, 5'h06, 1'b0);
    single("sltiu", 2'b10, 1'b1, 7'h55, 3'd3, 0, 5'h0E, 1'b0);
    single("br010", 2'b01, 1'b0, 7'h00, 3'd2, 0, 5'h03, 1'b1);
    single("lui",   2'b11, 1'b0, 7'h00, 3'd0, 0, 5'h0D, 1'b0);

    // DIV for 8 cycles, with an XOR held behind it
    set_in(1'b1, 2'b10, 1'b0, 7'h01, 3'd4);
    tick;
    set_in(1'b1, 2'b10, 1'b0, 7'h00, 3'd4);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("div_op_c%0d", k), 32'(d_op[0]), 32'h14);
      chk($sformatf("div_valid_c%0d", k), 32'(d_vld[0]), 32'd1);
      chk($sformatf("div_last_c%0d", k), 32'(d_last[0]), 32'(k == 8));
      chk($sformatf("div_ready_c%0d", k), 32'(d_rdy[0]), 32'(k == 8));
      tick;
    end
    chk("xor_after_div_op", 32'(d_op[0]), 32'h02);
    chk("xor_after_div_valid", 32'(d_vld[0]), 32'd1);
    chk("xor_after_div_last", 32'(d_last[0]), 32'd1);
    in_valid = 1'b0;
    tick;
    chk("xor_after_div_done", 32'(d_vld[0]), 32'd0);

    // MUL on the M-disabled instance is an illegal single-cycle ADD
    single("nom_mul", 2'b10, 1'b0, 7'h01, 3'd0, 1, 5'h03, 1'b1);
    for (int k = 0; k < 4; k++) tick;

    // flush in the 3rd BUSY cycle of MULH (MUL_CYCLES=4)
    set_in(1'b1, 2'b10, 1'b0, 7'h01, 3'd1);
    tick;
    in_valid = 1'b0;
    chk("mulh_op", 32'(d_op[0]), 32'h11);
    tick;
    tick;
    chk("mulh_busy3_valid", 32'(d_vld[0]), 32'd1);
    chk("mulh_busy3_ready", 32'(d_rdy[0]), 32'd0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_valid", 32'(d_vld[0]), 32'd0);
    chk("flush_last", 32'(d_last[0]), 32'd0);
    chk("flush_ready", 32'(d_rdy[0]), 32'd1);

    // input presented during flush is discarded
    flush = 1'b1;
    set_in(1'b1, 2'b00, 1'b0, 7'h00, 3'd0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept_valid", 32'(d_vld[0]), 32'd0);
    tick;

    // reset wins over a simultaneous in_valid
    reset = 1'b1;
    set_in(1'b1, 2'b10, 1'b0, 7'h20, 3'd0);
    tick;
    chk_reset_vals("reset_iv");
    reset = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("reset_iv_after", 32'(d_vld[0]), 32'd0);

    // back-to-back branches
    set_in(1'b1, 2'b01, 1'b0, 7'h00, 3'd0);
    tick;
    chk("beq_op", 32'(d_op[0]), 32'h08);
    chk("beq_valid", 32'(d_vld[0]), 32'd1);
    set_in(1'b1, 2'b01, 1'b0, 7'h00, 3'd1);
    tick;
    chk("bne_op", 32'(d_op[0]), 32'h09);
    chk("bne_valid", 32'(d_vld[0]), 32'd1);
    set_in(1'b1, 2'b01, 1'b0, 7'h00, 3'd7);
    tick;
    chk("bgeu_op", 32'(d_op[0]), 32'h0F);
    chk("bgeu_valid", 32'(d_vld[0]), 32'd1);
    chk("bgeu_last", 32'(d_last[0]), 32'd1);
    in_valid = 1'b0;
    tick;
    chk("b2b_done", 32'(d_vld[0]), 32'd0);
    tick;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
